// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and count constants for the kitchen timer
package timer_pkg;
  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] DEF_MAX_COUNT = 12'd3599;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET   = 2'd1,
    RUN   = 2'd2,
    ALARM = 2'd3
  } state_t;
endpackage

// File: rtl/countdown_sequencer_if.sv
// countdown_sequencer_if: button pulses in, count/status out
// master drives btn_up/btn_down/btn_start/btn_clear and observes count/running/alarm/tick;
// slave (the sequencer) is the reverse.
interface countdown_sequencer_if;
  import timer_pkg::*;
  logic             btn_up;
  logic             btn_down;
  logic             btn_start;
  logic             btn_clear;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             alarm;
  logic             tick;
  modport master (
    output btn_up, btn_down, btn_start, btn_clear,
    input  count, running, alarm, tick
  );
  modport slave (
    input  btn_up, btn_down, btn_start, btn_clear,
    output count, running, alarm, tick
  );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle terminal pulse every TICK_DIV cycles
// ports: clk, rst (async, active-high), i_en (count while high), i_restart (reload to 0),
// o_tc (high while the counter sits at TICK_DIV-1 and counting is enabled).
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tc
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] r_cnt;
  assign o_tc = i_en && r_cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= (!i_en || i_restart || o_tc) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: set/run/alarm FSM owning the seconds count of the kitchen timer
// ports: clk, rst (async, active-high), bus (slave): btn_* one-cycle pulses in,
// count/running/alarm/tick registered out.
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int               TICK_DIV    = 50_000_000,
  parameter logic [CNT_W-1:0] MAX_COUNT   = DEF_MAX_COUNT,
  parameter int               ALARM_TICKS = 30
) (
  input logic                  clk,
  input logic                  rst,
  countdown_sequencer_if.slave bus
);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] LAST_A = AW'(ALARM_TICKS - 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_count, w_count, w_inc, w_dec;
  logic [AW-1:0]    r_acnt, w_acnt;
  logic             r_running, r_alarm, r_tick;
  logic             w_tc, w_en, w_restart;
  assign w_en = r_state == RUN || r_state == ALARM;
  // any state change reloads the prescaler so each RUN/ALARM entry starts a full second
  assign w_restart = w_next != r_state;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_restart(w_restart),
    .o_tc     (w_tc)
  );
  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    w_acnt  = '0;
    w_inc   = r_count == MAX_COUNT ? '0 : r_count + CNT_W'(1);
    w_dec   = r_count == '0 ? '0 : r_count - CNT_W'(1);
    case (r_state)
      IDLE, SET: begin
        if (bus.btn_clear) begin
          w_next  = IDLE;
          w_count = '0;
        end else if (bus.btn_start) begin
          w_next = r_state == SET ? RUN : IDLE;
        end else if (bus.btn_up || bus.btn_down) begin
          w_count = bus.btn_up ? w_inc : w_dec;
          w_next  = w_count != '0 ? SET : IDLE;
        end
      end
      RUN: begin
        if (bus.btn_clear) begin
          w_next  = IDLE;
          w_count = '0;
        end else if (bus.btn_start) begin
          w_next = SET;
        end else if (w_tc) begin
          w_count = w_dec;
          w_next  = r_count == CNT_W'(1) ? ALARM : RUN;
        end
      end
      ALARM: begin
        w_count = '0;
        if (bus.btn_start || bus.btn_clear) begin
          w_next = IDLE;
        end else if (w_tc) begin
          w_next = r_acnt == LAST_A ? IDLE : ALARM;
          w_acnt = r_acnt == LAST_A ? '0 : r_acnt + AW'(1);
        end else begin
          w_acnt = r_acnt;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_acnt    <= '0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count;
      r_acnt    <= w_acnt;
      r_running <= w_next == RUN;
      r_alarm   <= w_next == ALARM;
      // a tick overridden by start/clear does nothing, so it is not reported
      r_tick    <= w_tc && !bus.btn_start && !bus.btn_clear;
    end
  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.alarm   = r_alarm;
  assign bus.tick    = r_tick;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: scoreboard bench for countdown_sequencer with TICK_DIV=4, MAX_COUNT=5, ALARM_TICKS=2
module tb_countdown_sequencer;
  typedef struct packed {
    logic [11:0] c;
    logic        r;
    logic        a;
    logic        t;
  } exp_t;
  typedef struct packed {
    logic [3:0]  b;
    logic [11:0] c;
    logic        r;
    logic        a;
    logic        t;
  } step_t;
  localparam logic [3:0] N = 4'b0000, D = 4'b0001, U = 4'b0010, S = 4'b0100, C = 4'b1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;
  exp_t sb[$];
  countdown_sequencer_if bus ();
  countdown_sequencer #(
    .TICK_DIV   (4),
    .MAX_COUNT  (12'd5),
    .ALARM_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic step_t st(input logic [3:0] b, input int c, input bit r, input bit a, input bit t);
    st = '{b: b, c: 12'(c), r: r, a: a, t: t};
  endfunction
  task automatic cyc(input logic [3:0] b);
    {bus.btn_clear, bus.btn_start, bus.btn_up, bus.btn_down} = b;
    @(posedge clk);
    #1;
    {bus.btn_clear, bus.btn_start, bus.btn_up, bus.btn_down} = N;
  endtask
  task automatic test_reset;
    exp_t e;
    {bus.btn_clear, bus.btn_start, bus.btn_up, bus.btn_down} = U;
    sb.push_back('{c: 12'd0, r: 1'b0, a: 1'b0, t: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
      $display("FAIL reset: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
               bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
    else pass_cnt++;
    {bus.btn_clear, bus.btn_start, bus.btn_up, bus.btn_down} = N;
    rst = 1'b0;
  endtask
  task automatic test_updown;
    step_t s[8];
    exp_t  e;
    s = '{st(U,1,0,0,0), st(U,2,0,0,0), st(U,3,0,0,0), st(U,4,0,0,0),
          st(U,5,0,0,0), st(U,0,0,0,0), st(D,0,0,0,0), st(S,0,0,0,0)};
    foreach (s[i]) begin
      sb.push_back({s[i].c, s[i].r, s[i].a, s[i].t});
      cyc(s[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL updown step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
  endtask
  task automatic test_countdown;
    step_t s[20];
    exp_t  e;
    s = '{st(U,1,0,0,0), st(U,2,0,0,0), st(S,2,1,0,0),
          st(N,2,1,0,0), st(N,2,1,0,0), st(N,2,1,0,0), st(N,1,1,0,1),
          st(N,1,1,0,0), st(N,1,1,0,0), st(N,1,1,0,0), st(N,0,0,1,1),
          st(N,0,0,1,0), st(N,0,0,1,0), st(N,0,0,1,0), st(N,0,0,1,1),
          st(N,0,0,1,0), st(N,0,0,1,0), st(N,0,0,1,0), st(N,0,0,0,1),
          st(N,0,0,0,0)};
    foreach (s[i]) begin
      sb.push_back({s[i].c, s[i].r, s[i].a, s[i].t});
      cyc(s[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL countdown step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
  endtask
  task automatic test_pause;
    step_t s[15];
    exp_t  e;
    s = '{st(U,1,0,0,0), st(U,2,0,0,0), st(U,3,0,0,0), st(S,3,1,0,0),
          st(N,3,1,0,0), st(N,3,1,0,0), st(N,3,1,0,0), st(S,3,0,0,0),
          st(N,3,0,0,0), st(S,3,1,0,0), st(N,3,1,0,0), st(N,3,1,0,0),
          st(N,3,1,0,0), st(N,2,1,0,1), st(C,0,0,0,0)};
    foreach (s[i]) begin
      sb.push_back({s[i].c, s[i].r, s[i].a, s[i].t});
      cyc(s[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL pause step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
  endtask
  task automatic test_priority;
    step_t s[11];
    exp_t  e;
    s = '{st(U,1,0,0,0), st(U,2,0,0,0), st(C|U,0,0,0,0), st(S,0,0,0,0),
          st(U,1,0,0,0), st(S,1,1,0,0), st(U,1,1,0,0), st(D,1,1,0,0),
          st(N,1,1,0,0), st(N,0,0,1,1), st(S,0,0,0,0)};
    foreach (s[i]) begin
      sb.push_back({s[i].c, s[i].r, s[i].a, s[i].t});
      cyc(s[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL priority step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
  endtask
  task automatic test_async_reset;
    step_t pre[5];
    step_t post[7];
    exp_t  e;
    pre = '{st(U,1,0,0,0), st(U,2,0,0,0), st(S,2,1,0,0), st(N,2,1,0,0), st(N,2,1,0,0)};
    post = '{st(U,1,0,0,0), st(S,1,1,0,0), st(N,1,1,0,0), st(N,1,1,0,0),
             st(N,1,1,0,0), st(N,0,0,1,1), st(C,0,0,0,0)};
    foreach (pre[i]) begin
      sb.push_back({pre[i].c, pre[i].r, pre[i].a, pre[i].t});
      cyc(pre[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL async_pre step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
    #2 rst = 1'b1;
    sb.push_back('{c: 12'd0, r: 1'b0, a: 1'b0, t: 1'b0});
    #1;
    e = sb.pop_front();
    total++;
    if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
      $display("FAIL async_reset: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
               bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
    else pass_cnt++;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (post[i]) begin
      sb.push_back({post[i].c, post[i].r, post[i].a, post[i].t});
      cyc(post[i].b);
      e = sb.pop_front();
      total++;
      if ({bus.count, bus.running, bus.alarm, bus.tick} !== e)
        $display("FAIL async_post step %0d: got count=%0d run=%b alarm=%b tick=%b want count=%0d run=%b alarm=%b tick=%b",
                 i, bus.count, bus.running, bus.alarm, bus.tick, e.c, e.r, e.a, e.t);
      else pass_cnt++;
    end
  endtask
  initial begin
    {bus.btn_clear, bus.btn_start, bus.btn_up, bus.btn_down} = N;
    test_reset();
    test_updown();
    test_countdown();
    test_pause();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Sequential core of the kitchen timer. It owns the 12-bit seconds count register and applies single-step up/down edits while the timer is being set. It runs a prescaled once-per-second countdown and raises the alarm at zero. It sits between the debounced button pulses and the display/alarm drivers; its step arithmetic matches the existing combinational counter.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick.
- `MAX_COUNT`, default 12'd3599: largest settable count (59:59).
- `ALARM_TICKS`, default 30: ticks the alarm stays asserted before auto-clearing.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_up`  in  1: one-cycle pulse; increment count.
- `btn_down`  in  1: one-cycle pulse; decrement count.
- `btn_start`  in  1: one-cycle pulse; start/pause toggle, also acknowledges the alarm.
- `btn_clear`  in  1: one-cycle pulse; stop and zero the count.
- `count`  out  12: current seconds value.
- `running`  out  1: high in RUN.
- `alarm`  out  1: high in ALARM.
- `tick`  out  1: one-cycle pulse on every registered tick in RUN or ALARM.

## Operation
- States: IDLE (count==0, stopped), SET (count>0, stopped), RUN, ALARM.
- Reset, at any time including mid-run: state=IDLE, count=0, prescaler=0, alarm counter=0. All outputs are 0.
- Input priority when several inputs are active in one cycle: `btn_clear` > `btn_start` > `btn_up` > `btn_down`. Only the highest-priority active input acts.
- IDLE/SET behaviour:
  - `btn_up` increments count. At MAX_COUNT it wraps to 0.
  - `btn_down` decrements count. At 0 it holds 0; there is no underflow wrap.
  - The state becomes SET if the new count is nonzero, otherwise IDLE.
- `btn_start` in SET goes to RUN. In IDLE it is ignored.
- In RUN:
  - up/down are ignored.
  - On a tick, count decrements by 1. If the pre-tick count is 1, count becomes 0 and the state goes to ALARM.
  - `btn_start` goes to SET with count held (pause). If a tick falls in the same cycle, the pause wins and no decrement occurs.
  - `btn_clear` goes to IDLE with count=0.
- In ALARM:
  - count stays 0.
  - Any `btn_start` or `btn_clear` goes to IDLE.
  - Otherwise the state goes to IDLE after ALARM_TICKS ticks.
  - up/down are ignored.
- Count arithmetic is 12-bit unsigned, with no intermediate width growth. The count never exceeds MAX_COUNT.

## Timing
- All outputs are registered. An input pulse sampled at edge k is visible on the outputs after edge k.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and ALARM only.
  - It is forced to 0 in IDLE/SET and on every entry into RUN or ALARM.
- Tick event: the prescaler equals TICK_DIV-1 at an edge. At that edge the prescaler reloads to 0, count updates and `tick` is asserted for exactly that following cycle.
- `btn_start` at edge k enters RUN. The first decrement is at edge k+TICK_DIV, and subsequent decrements follow every TICK_DIV cycles.
- The pause/resume prescaler restart is intended: each resume gives a full first second.
- Entry into ALARM: `alarm`=1 and `running`=0 in the same cycle that count shows 0. The alarm counter starts at 0 on entry.
- Auto-clear: IDLE is entered at the ALARM_TICKS-th tick after ALARM entry.

## Structure
- Shared package `timer_pkg`:
  - State encoding (IDLE=2'd0, SET=2'd1, RUN=2'd2, ALARM=2'd3).
  - Count width constant 12.
  - Default MAX_COUNT.
- One sub-module, `tick_prescaler`:
  - Inputs: `clk`, `rst`, enable, restart.
  - Output: terminal pulse.
  - Parameter: TICK_DIV.
- The FSM, count register and alarm counter live in `countdown_sequencer`.

## Test plan
Test parameters: TICK_DIV=4, MAX_COUNT=5, ALARM_TICKS=2.
- Reset, then three `btn_up` pulses -> count=3, state SET. Then three more -> count 0 after wrap at 5, state IDLE.
- In IDLE with count=0, `btn_down` -> count stays 0. Then `btn_start` -> `running` stays 0.
- count=2, `btn_start` at edge k -> decrements at k+4 and k+8 with `tick` pulses. At k+8: count=0, `alarm`=1, `running`=0. `alarm` falls at k+16.
- In RUN, `btn_start` coincident with the tick edge -> count unchanged, state SET. Resume -> next decrement 4 cycles later.
- `btn_clear` and `btn_up` in the same cycle during SET -> count=0, state IDLE. `btn_up` during RUN -> ignored.
- Assert `rst` mid-RUN between edges -> count=0 and `running`=0 immediately (asynchronous). The prescaler restarts from 0 after release.
